// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-ported word memory.
// Byte-enabled stores become read-modify-write sequences (memory only takes full words).
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       r0_req,
  input  logic                       r0_we,
  input  logic [DMEM_ADDR_WIDTH+1:0] r0_addr,
  input  logic [31:0]                r0_wdata,
  input  logic [3:0]                 r0_be,
  output logic                       r0_gnt,
  output logic                       r0_rvalid,
  input  logic                       r1_req,
  input  logic                       r1_we,
  input  logic [DMEM_ADDR_WIDTH+1:0] r1_addr,
  input  logic [31:0]                r1_wdata,
  input  logic [3:0]                 r1_be,
  output logic                       r1_gnt,
  output logic                       r1_rvalid,
  output logic [31:0]                rdata,
  output logic [DMEM_ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]                m_din,
  output logic                       m_read,
  output logic                       m_write,
  input  logic [31:0]                m_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                     state_q, state_d;
  logic                       last_q, last_d;
  logic                       owner_q, owner_d;
  logic                       we_q, we_d;
  logic [3:0]                 be_q, be_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                din_q, din_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [1:0]                 rvalid_q, rvalid_d;

  logic                       gnt0_c, gnt1_c;
  logic                       w_we;
  logic [3:0]                 w_be;
  logic [31:0]                w_wdata;
  logic [DMEM_ADDR_WIDTH+1:0] w_addr;
  logic                       unused_addr_lsbs;

  function automatic logic [31:0] merge_bytes(input logic [31:0] wd, input logic [31:0] rd,
                                              input logic [3:0] be);
    logic [31:0] res;
    res = rd;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  // last_q = 1 means port 1 was granted last, so port 0 wins the next tie
  assign gnt0_c = (state_q == IDLE) & r0_req & (~r1_req | last_q);
  assign gnt1_c = (state_q == IDLE) & r1_req & (~r0_req | ~last_q);

  assign w_we    = gnt1_c ? r1_we    : r0_we;
  assign w_be    = gnt1_c ? r1_be    : r0_be;
  assign w_wdata = gnt1_c ? r1_wdata : r0_wdata;
  assign w_addr  = gnt1_c ? r1_addr  : r0_addr;

  assign unused_addr_lsbs = ^{r0_addr[1:0], r1_addr[1:0]};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    m_read   = 1'b0;
    m_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt0_c | gnt1_c) begin
          owner_d = gnt1_c;
          last_d  = gnt1_c;
          we_d    = w_we;
          be_d    = w_be;
          addr_d  = w_addr[DMEM_ADDR_WIDTH+1:2];
          din_d   = w_wdata;
          if (!w_we)                state_d = READ;
          else if (w_be == 4'b1111) state_d = WRITE;
          else if (w_be == 4'b0000) state_d = IDLE;
          else                      state_d = READ;
        end
      end
      READ: begin
        m_read = 1'b1;
        if (!we_q) begin
          rdata_d           = m_dout;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end else begin
          din_d   = merge_bytes(din_q, m_dout, be_q);
          state_d = WRITE;
        end
      end
      WRITE: begin
        m_write = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Grants are suppressed while reset is held even though the state already reads IDLE
  assign r0_gnt    = gnt0_c & reset_b;
  assign r1_gnt    = gnt1_c & reset_b;
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign rdata     = rdata_q;
  assign m_addr    = addr_q;
  assign m_din     = din_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported, word-wide data memory. It shares the memory between two requesters: port 0 is the core load/store unit and port 1 is the debug/loader port. Arbitration is round-robin. Byte-enabled stores are turned into read-modify-write sequences, because the memory only supports full 32-bit writes.

## Interface
Parameters:
- DMEM_ADDR_WIDTH, default 10: memory word-address width. Requester addresses are byte addresses, DMEM_ADDR_WIDTH+2 bits wide.

Ports (N = 0, 1):
- clk  in  1  clock; all state updates on rising edge
- reset_b  in  1  asynchronous, active-low reset
- rN_req  in  1  request valid; held until rN_gnt is sampled high
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  DMEM_ADDR_WIDTH+2  byte address; bits [1:0] ignored (aligned accesses only)
- rN_wdata  in  32  write data, byte lanes aligned to the word
- rN_be  in  4  byte enables for writes; ignored on reads
- rN_gnt  out  1  request accepted this cycle (combinational, IDLE only)
- rN_rvalid  out  1  one-cycle pulse: read data for port N is valid
- rdata  out  32  read data, shared by both ports, qualified by rN_rvalid
- m_addr  out  DMEM_ADDR_WIDTH  memory word address
- m_din  out  32  memory write data
- m_read  out  1  memory read enable
- m_write  out  1  memory write enable; memory writes on rising clk edge
- m_dout  in  32  memory read data (combinational from m_addr)

## Operation
- States: IDLE, READ, WRITE.
- **IDLE:**
  - m_read = m_write = 0.
  - If any rN_req is high, exactly one rN_gnt is asserted.
  - On the clock edge the winner's we, word address (addr[DMEM_ADDR_WIDTH+1:2]), wdata and be are latched, along with the owner ID.
- **Arbitration:**
  - A single requester wins unconditionally.
  - If both request, the port not granted last time wins.
  - The last-grant register resets to 1, so port 0 wins the first tie.
- **Transition out of IDLE** (on the accept edge):
  - Read → READ.
  - Write with be = 4'b1111 → WRITE.
  - Write with be = 0000 → no memory access; stay in IDLE (granted no-op).
  - Write with any other be → READ (merge phase).
- **READ:**
  - m_read = 1, m_addr = latched address.
  - On the edge, m_dout is captured.
  - For a read request: rdata ← m_dout, owner's rvalid set for the next cycle, next state IDLE.
  - For a partial write: merge register byte i ← be[i] ? wdata byte i : m_dout byte i, next state WRITE.
- **WRITE:**
  - m_write = 1, m_din = merged data (or wdata for a full write), m_addr = latched address.
  - The memory updates on the edge; next state IDLE.
  - No response is sent for writes; the grant is the acknowledgement.
- m_addr and m_din hold their last latched values in IDLE.
- rN_gnt = 0 in READ and WRITE; requests wait.

## Timing
- Reset values: state IDLE; rN_gnt 0; rN_rvalid 0; rdata 0; m_addr 0; m_din 0; m_read 0; m_write 0; last-grant = 1.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. A pending WRITE is abandoned, and memory is not written unless the write edge occurred before reset.
- Read: gnt in cycle T, m_read in T+1, rvalid and rdata in T+2. rdata holds until the next read completes.
- Full write: gnt in T, m_write in T+1.
- Partial write: gnt in T, m_read in T+1, m_write in T+2.
- The rvalid cycle is IDLE, so a new request can be granted in that same cycle.
- Peak throughput: one read per 2 cycles, one full write per 2 cycles, one partial write per 3 cycles.
- A requester deasserting req before gnt is legal; nothing is latched.

## Test plan
- Reset, memory word 5 = 0x11223344; r0 reads byte address 0x14 → r0_gnt in T, m_read in T+1, r0_rvalid = 1 and rdata = 0x11223344 in T+2, r1_rvalid stays 0.
- r1 full write: addr 0x20, wdata 0xDEADBEEF, be 1111 → m_write = 1 in T+1 with m_addr = 8; a following read of 0x20 returns 0xDEADBEEF.
- Word 5 = 0x11223344; r0 write: be 0101, wdata 0xAABBCCDD → m_read in T+1, m_write in T+2 with m_din = 0x11BB33DD.
- r0 and r1 both hold req continuously after reset → grants alternate r0, r1, r0, r1; no cycle has both gnt high.
- r0 write with be 0000 → r0_gnt high; m_read and m_write never asserted; next request granted in T+1.
- reset_b pulled low during the WRITE cycle of a partial write → outputs go to reset values immediately; target word unchanged; first tie after release goes to r0.
